// File: rtl/gate_code_pkg.sv
// Shared definitions for the three-input gate family: code values, their
// truth tables, and the characterizer state encoding.
package gate_code_pkg;

  localparam logic [1:0] CODE_XOR3  = 2'b00;
  localparam logic [1:0] CODE_NAND3 = 2'b01;
  localparam logic [1:0] CODE_NOR3  = 2'b10;
  localparam logic [1:0] CODE_XNOR3 = 2'b11;

  // Bit i is f for {a,b,c} = i, with a as the MSB.
  localparam logic [7:0] TT_XOR3  = 8'h96;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XNOR3 = 8'h69;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_EVAL  = 2'b10
  } state_t;

endpackage

// File: rtl/gate_truth_matcher.sv
// Combinational lookup from an observed 8-bit truth table to a gate code.
// No match yields code XOR3 with match low.
module gate_truth_matcher
  import gate_code_pkg::*;
(
  input  logic [7:0] truth,
  output logic       match,
  output logic [1:0] code
);

  always_comb begin
    match = 1'b1;
    code  = CODE_XOR3;
    if (truth == TT_XOR3)       code = CODE_XOR3;
    else if (truth == TT_NAND3) code = CODE_NAND3;
    else if (truth == TT_NOR3)  code = CODE_NOR3;
    else if (truth == TT_XNOR3) code = CODE_XNOR3;
    else                        match = 1'b0;
  end

endmodule

// File: rtl/gate_code_identifier.sv
// Drives all eight {a,b,c} vectors into a gate under test, captures its
// response and identifies which of the four gate codes it implements.
//
// Handshake: i_start is a level sampled only in IDLE; i_abort is a level
// sampled only in DRIVE/EVAL and wins over i_start there. o_done is a
// one-cycle pulse coincident with the result registers updating.
module gate_code_identifier
  import gate_code_pkg::*;
#(
  parameter int RESP_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_truth,
  output logic [1:0] o_code,
  output logic       o_match,
  output state_t     o_state
);

  localparam logic [2:0] HOLD_LAST = 3'(RESP_LAT);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [2:0] hold, hold_n;
  logic [7:0] scratch, scratch_n;
  logic       publish;
  logic       eval_match;
  logic [1:0] eval_code;

  gate_truth_matcher u_matcher (
    .truth (scratch),
    .match (eval_match),
    .code  (eval_code)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    hold_n    = hold;
    scratch_n = scratch;
    publish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_n   = ST_DRIVE;
          idx_n     = 3'd0;
          hold_n    = 3'd0;
          scratch_n = 8'h00;
        end
      end
      ST_DRIVE: begin
        if (i_abort) begin
          state_n = ST_IDLE;
        end else if (hold == HOLD_LAST) begin
          // Last hold cycle: the response to this vector is valid now.
          scratch_n[idx] = i_f;
          hold_n         = 3'd0;
          if (idx == 3'd7) state_n = ST_EVAL;
          else             idx_n   = idx + 3'd1;
        end else begin
          hold_n = hold + 3'd1;
        end
      end
      ST_EVAL: begin
        state_n = ST_IDLE;
        publish = !i_abort;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      idx             <= 3'd0;
      hold            <= 3'd0;
      scratch         <= 8'h00;
      {o_a, o_b, o_c} <= 3'b000;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_truth         <= 8'h00;
      o_code          <= CODE_XOR3;
      o_match         <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      hold            <= hold_n;
      scratch         <= scratch_n;
      {o_a, o_b, o_c} <= (state_n == ST_DRIVE) ? idx_n : 3'b000;
      o_busy          <= (state_n != ST_IDLE);
      o_done          <= publish;
      if (publish) begin
        o_truth <= scratch;
        o_code  <= eval_code;
        o_match <= eval_match;
      end
    end
  end

  assign o_state = state;

endmodule
